// File: rtl/rom_fetch_sequencer.sv
// Shares one registered-read character ROM among NUM_DIG digit-address requesters.
// The patterns of a sweep are gathered in a shadow bank and committed to sseg_bank in one edge.
module rom_fetch_sequencer #(
   parameter int unsigned          ADDR_W  = 7,
   parameter int unsigned          DATA_W  = 8,
   parameter int unsigned          NUM_DIG = 4,
   parameter int unsigned          ROM_LAT = 1,
   parameter logic [DATA_W-1:0]    BLANK   = 8'hFF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_DIG*ADDR_W-1:0]   addr_vec,
   input  logic                        force_refresh,
   output logic [ADDR_W-1:0]           rom_addr,
   output logic                        rom_en,
   input  logic [DATA_W-1:0]           rom_data,
   output logic [NUM_DIG*DATA_W-1:0]   sseg_bank,
   output logic                        bank_valid,
   output logic                        busy,
   output logic                        update_pulse
);

   localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
   localparam int unsigned CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t                      state, state_n;
   logic [IDX_W-1:0]            idx, idx_n;
   logic [CNT_W-1:0]            cnt, cnt_n;
   logic [NUM_DIG*ADDR_W-1:0]   snap, snap_n;
   logic                        pend, pend_n;
   logic                        capture;
   logic                        commit;
   logic [DATA_W-1:0]           shadow [NUM_DIG];
   logic [NUM_DIG*DATA_W-1:0]   bank_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         cnt          <= '0;
         snap         <= '0;
         pend         <= 1'b1;
         sseg_bank    <= {NUM_DIG{BLANK}};
         bank_valid   <= 1'b0;
         update_pulse <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIG; i++) begin
            shadow[i] <= BLANK;
         end
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         cnt          <= cnt_n;
         snap         <= snap_n;
         pend         <= pend_n;
         update_pulse <= commit;
         if (capture) begin
            shadow[idx] <= rom_data;
         end
         if (commit) begin
            sseg_bank  <= bank_n;
            bank_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      snap_n  = snap;
      pend_n  = pend;
      capture = 1'b0;
      commit  = 1'b0;
      case (state)
         S_IDLE: begin
            // A refresh arriving on the start edge is absorbed by this sweep.
            if ((addr_vec != snap) || force_refresh || pend) begin
               state_n = S_ISSUE;
               snap_n  = addr_vec;
               pend_n  = 1'b0;
               idx_n   = '0;
            end
         end
         S_ISSUE: begin
            state_n = S_WAIT;
            cnt_n   = '0;
            if (force_refresh) pend_n = 1'b1;
         end
         S_WAIT: begin
            if (force_refresh) pend_n = 1'b1;
            if (cnt == LAST_CNT) begin
               capture = 1'b1;
               if (idx == LAST_IDX) begin
                  commit  = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = S_ISSUE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Last digit bypasses the shadow so the commit lands on its capture edge.
   always_comb begin
      bank_n = '0;
      for (int unsigned i = 0; i < NUM_DIG - 1; i++) begin
         bank_n[i*DATA_W +: DATA_W] = shadow[i];
      end
      bank_n[(NUM_DIG-1)*DATA_W +: DATA_W] = rom_data;
   end

   assign busy     = (state != S_IDLE);
   assign rom_en   = (state == S_ISSUE);
   assign rom_addr = busy ? snap[idx*ADDR_W +: ADDR_W] : '0;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Randomized self-checking bench: one DUT with ROM_LAT=1, one with ROM_LAT=2, each fed by a ROM model.
module tb_rom_fetch_sequencer;

   localparam int ND = 4;

   logic        clk;
   logic        rst_v      [2];
   logic [27:0] addr_vec_v [2];
   logic        force_v    [2];
   logic [6:0]  rom_addr_v [2];
   logic        rom_en_v   [2];
   logic [7:0]  rom_data_v [2];
   logic [31:0] bank_v     [2];
   logic        bv_v       [2];
   logic        busy_v     [2];
   logic        up_v       [2];

   int vecs = 0;
   int errs = 0;
   int pulses [2];

   logic [7:0] p1_0, q2_0, q2_1;
   logic [31:0] bank0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rom_fetch_sequencer #(.ADDR_W(7), .DATA_W(8), .NUM_DIG(ND), .ROM_LAT(1), .BLANK(8'hFF)) dut1 (
      .clk(clk), .rst(rst_v[0]), .addr_vec(addr_vec_v[0]), .force_refresh(force_v[0]),
      .rom_addr(rom_addr_v[0]), .rom_en(rom_en_v[0]), .rom_data(rom_data_v[0]),
      .sseg_bank(bank_v[0]), .bank_valid(bv_v[0]), .busy(busy_v[0]), .update_pulse(up_v[0]));

   rom_fetch_sequencer #(.ADDR_W(7), .DATA_W(8), .NUM_DIG(ND), .ROM_LAT(2), .BLANK(8'hFF)) dut2 (
      .clk(clk), .rst(rst_v[1]), .addr_vec(addr_vec_v[1]), .force_refresh(force_v[1]),
      .rom_addr(rom_addr_v[1]), .rom_en(rom_en_v[1]), .rom_data(rom_data_v[1]),
      .sseg_bank(bank_v[1]), .bank_valid(bv_v[1]), .busy(busy_v[1]), .update_pulse(up_v[1]));

   // ROM models: data appears only for issued reads, otherwise X.
   always @(posedge clk) begin
      p1_0 <= rom_en_v[0] ? ({1'b0, rom_addr_v[0]} ^ 8'hA5) : 8'hxx;
      q2_0 <= rom_en_v[1] ? ({1'b0, rom_addr_v[1]} ^ 8'hA5) : 8'hxx;
      q2_1 <= q2_0;
   end
   assign rom_data_v[0] = p1_0;
   assign rom_data_v[1] = q2_1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) if (up_v[d] === 1'b1) pulses[d]++;
   end

   function automatic logic [31:0] model_bank(input logic [27:0] a);
      logic [31:0] b;
      for (int i = 0; i < ND; i++) b[i*8 +: 8] = {1'b0, a[i*7 +: 7]} ^ 8'hA5;
      return b;
   endfunction

   // Called #1 after the start edge E0; returns #1 after the commit edge.
   task automatic check_sweep(input int d, input logic [27:0] snap, input logic [31:0] old_bank,
                              input int chg_k, input logic [27:0] chg_val, input logic [31:0] fmask,
                              output logic [31:0] new_bank);
      int L, ec;
      logic [31:0] nb, exp_bank;
      logic exp_en, exp_busy, exp_up;
      L  = d + 1;
      ec = ND * (L + 1);
      nb = model_bank(snap);
      for (int k = 0; k <= ec; k++) begin
         force_v[d] = 1'b0;
         exp_en   = (k < ec) && ((k % (L + 1)) == 0);
         exp_busy = (k < ec);
         exp_up   = (k == ec);
         exp_bank = (k == ec) ? nb : old_bank;
         vecs++;
         if (rom_en_v[d] !== exp_en) begin
            errs++; $display("FAIL sweep_rom_en d%0d k%0d: got %b want %b", d, k, rom_en_v[d], exp_en);
         end
         vecs++;
         if (busy_v[d] !== exp_busy) begin
            errs++; $display("FAIL sweep_busy d%0d k%0d: got %b want %b", d, k, busy_v[d], exp_busy);
         end
         vecs++;
         if (up_v[d] !== exp_up) begin
            errs++; $display("FAIL sweep_update_pulse d%0d k%0d: got %b want %b", d, k, up_v[d], exp_up);
         end
         vecs++;
         if (bank_v[d] !== exp_bank) begin
            errs++; $display("FAIL sweep_bank d%0d k%0d: got %h want %h", d, k, bank_v[d], exp_bank);
         end
         if (k < ec) begin
            vecs++;
            if (rom_addr_v[d] !== snap[(k / (L + 1)) * 7 +: 7]) begin
               errs++; $display("FAIL sweep_rom_addr d%0d k%0d: got %0d want %0d", d, k,
                                rom_addr_v[d], snap[(k / (L + 1)) * 7 +: 7]);
            end
         end else begin
            vecs++;
            if (bv_v[d] !== 1'b1) begin
               errs++; $display("FAIL sweep_bank_valid d%0d: got %b want 1", d, bv_v[d]);
            end
         end
         if (k == chg_k) addr_vec_v[d] = chg_val;
         if (fmask[k]) force_v[d] = 1'b1;
         if (k < ec) begin
            @(posedge clk); #1;
         end
      end
      new_bank = nb;
   endtask

   task automatic idle_check(input int d, input int n, input logic [31:0] bank);
      for (int c = 0; c < n; c++) begin
         vecs++;
         if (rom_en_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || up_v[d] !== 1'b0) begin
            errs++; $display("FAIL idle_ctrl d%0d c%0d: got en=%b busy=%b up=%b want 0 0 0",
                             d, c, rom_en_v[d], busy_v[d], up_v[d]);
         end
         vecs++;
         if (bank_v[d] !== bank) begin
            errs++; $display("FAIL idle_bank d%0d c%0d: got %h want %h", d, c, bank_v[d], bank);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_pulses(input int d, input int base, input int want);
      vecs++;
      if (pulses[d] - base !== want) begin
         errs++; $display("FAIL pulse_count d%0d: got %0d want %0d", d, pulses[d] - base, want);
      end
   endtask

   task automatic check_reset_outputs(input int d);
      vecs++;
      if (bank_v[d] !== 32'hFFFF_FFFF || bv_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
          rom_en_v[d] !== 1'b0 || up_v[d] !== 1'b0 || rom_addr_v[d] !== 7'd0) begin
         errs++; $display("FAIL reset_outputs d%0d: got bank=%h bv=%b busy=%b en=%b up=%b addr=%0d want ffffffff 0 0 0 0 0",
                          d, bank_v[d], bv_v[d], busy_v[d], rom_en_v[d], up_v[d], rom_addr_v[d]);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; force_v[d] = 1'b0; addr_vec_v[d] = '0;
      end
      #2;
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      #1;
      check_reset_outputs(0);
      check_reset_outputs(1);
   endtask

   task automatic test_first_sweep();
      logic [27:0] a;
      int base;
      a = {7'd29, 7'd27, 7'd16, 7'd22};
      addr_vec_v[0] = a;
      @(posedge clk); #1;
      check_reset_outputs(0);
      base = pulses[0];
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      check_sweep(0, a, 32'hFFFF_FFFF, -1, '0, '0, bank0);
      vecs++;
      if (bank0 !== 32'hB8BE_B5B3) begin
         errs++; $display("FAIL first_bank_model: got %h want b8beb5b3", bank0);
      end
      @(posedge clk); #1;
      idle_check(0, 4, bank0);
      check_pulses(0, base, 1);
   endtask

   task automatic test_idle_hold();
      idle_check(0, 200, bank0);
   endtask

   task automatic test_addr_change();
      logic [27:0] a, b;
      int base;
      base = pulses[0];
      a = addr_vec_v[0];
      a[2*7 +: 7] = 7'd27;
      a[0 +: 7] = a[0 +: 7] ^ 7'h11;
      b = a;
      b[2*7 +: 7] = 7'd0;
      addr_vec_v[0] = a;
      @(posedge clk); #1;
      check_sweep(0, a, bank0, 4, b, '0, bank0);
      vecs++;
      if (bank0[2*8 +: 8] !== 8'hBE) begin
         errs++; $display("FAIL addr_change_first_digit2: got %h want be", bank0[2*8 +: 8]);
      end
      @(posedge clk); #1;
      check_sweep(0, b, bank0, -1, '0, '0, bank0);
      vecs++;
      if (bank0[2*8 +: 8] !== 8'hA5) begin
         errs++; $display("FAIL addr_change_second_digit2: got %h want a5", bank0[2*8 +: 8]);
      end
      @(posedge clk); #1;
      idle_check(0, 5, bank0);
      check_pulses(0, base, 2);
   endtask

   task automatic test_force_refresh();
      int base;
      logic [27:0] a;
      base = pulses[0];
      a = addr_vec_v[0];
      force_v[0] = 1'b1;
      @(posedge clk); #1;
      check_sweep(0, a, bank0, -1, '0, 32'h0000_0026, bank0);
      @(posedge clk); #1;
      check_sweep(0, a, bank0, -1, '0, '0, bank0);
      @(posedge clk); #1;
      idle_check(0, 6, bank0);
      check_pulses(0, base, 2);
   endtask

   task automatic test_reset_mid();
      logic [27:0] a;
      int base;
      a = addr_vec_v[0] ^ 28'h0_0100_3;
      addr_vec_v[0] = a;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      #2;
      rst_v[0] = 1'b0;
      #1;
      check_reset_outputs(0);
      @(posedge clk); #1;
      check_reset_outputs(0);
      base = pulses[0];
      rst_v[0] = 1'b1;
      @(posedge clk); #1;
      check_sweep(0, a, 32'hFFFF_FFFF, -1, '0, '0, bank0);
      @(posedge clk); #1;
      idle_check(0, 4, bank0);
      check_pulses(0, base, 1);
   endtask

   task automatic test_random();
      logic [27:0] a, c;
      logic [31:0] fm;
      int mode, ck, base;
      bit extra;
      for (int it = 0; it < 10; it++) begin
         base = pulses[0];
         a = 28'($urandom());
         if (a == addr_vec_v[0]) a = a ^ 28'h1;
         c = 28'($urandom());
         if (c == a) c = c ^ 28'h80;
         mode = int'($urandom_range(0, 2));
         ck = -1; fm = '0;
         if (mode == 1) ck = int'($urandom_range(0, 7));
         if (mode == 2) fm = (32'($urandom()) & 32'h0000_00FF) | (32'h1 << $urandom_range(0, 7));
         extra = (mode != 0);
         addr_vec_v[0] = a;
         force_v[0] = 1'($urandom());
         @(posedge clk); #1;
         check_sweep(0, a, bank0, ck, c, fm, bank0);
         @(posedge clk); #1;
         if (extra) begin
            check_sweep(0, addr_vec_v[0], bank0, -1, '0, '0, bank0);
            @(posedge clk); #1;
         end
         idle_check(0, 3, bank0);
         check_pulses(0, base, extra ? 2 : 1);
      end
   endtask

   task automatic test_rom_lat2();
      logic [27:0] a, b;
      logic [31:0] bank1;
      int base;
      a = 28'($urandom());
      b = a ^ 28'h00_0007F;
      addr_vec_v[1] = a;
      base = pulses[1];
      rst_v[1] = 1'b1;
      @(posedge clk); #1;
      check_sweep(1, a, 32'hFFFF_FFFF, 5, b, 32'h0000_0200, bank1);
      @(posedge clk); #1;
      check_sweep(1, b, bank1, -1, '0, '0, bank1);
      @(posedge clk); #1;
      idle_check(1, 5, bank1);
      check_pulses(1, base, 2);
   endtask

   initial begin
      pulses[0] = 0; pulses[1] = 0;
      test_reset();
      test_first_sweep();
      test_idle_hold();
      test_addr_change();
      test_force_refresh();
      test_reset_mid();
      test_random();
      test_rom_lat2();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
